// File: rtl/fe_instr_dispatcher.sv
// Front-end dispatch stage: round-robin EU allocation, broadcast on the EU dispatch bus, retry on full.
// Optional: define FE_DISPATCH_STALL_CTR_EN to add a saturating RETRY-cycle counter (stall_cycles_o).
module fe_instr_dispatcher #(
  parameter int unsigned NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int unsigned LOG2_NUM_EXEC_UNITS           = 2,
  parameter int unsigned INSTR_W                       = 32
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][INSTR_W-1:0]    batch_instr_i,
  input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                 batch_instr_valid_i,
  input  logic                                                     batch_valid_i,
  output logic                                                     batch_ready_o,
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][INSTR_W-1:0]    dispatched_instr_o,
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                 dispatched_instr_valid_o,
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0]
                                                                   dispatched_instr_alloc_euidx_o,
  input  logic [(2**LOG2_NUM_EXEC_UNITS)-1:0]                      eu_is_full_i
`ifdef FE_DISPATCH_STALL_CTR_EN
  ,
  output logic [15:0]                                              stall_cycles_o
`endif
);

  localparam int unsigned N = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int unsigned L = LOG2_NUM_EXEC_UNITS;
  localparam logic [L-1:0] CtrOne = L'(1);

  typedef enum logic [1:0] {StIdle, StDispatch, StRetry} state_e;

  state_e                  state_q;
  logic [N-1:0]            pending_q;
  logic [N-1:0]            blocked;
  logic [N-1:0][INSTR_W-1:0] instr_q;
  logic [N-1:0][L-1:0]     euidx_q;
  logic [N-1:0][L-1:0]     euidx_new;
  logic [L-1:0]            alloc_ctr_q;
  logic [L-1:0]            alloc_ctr_new;
  logic                    accept;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      blocked[k] = pending_q[k] & eu_is_full_i[euidx_q[k]];
    end
  end

  assign batch_ready_o = (state_q == StIdle) | ~(|blocked);
  assign accept        = batch_valid_i & batch_ready_o;

  // Running counter gives each valid lane alloc_ctr + (number of valid lanes below it).
  always_comb begin
    alloc_ctr_new = alloc_ctr_q;
    for (int k = 0; k < N; k++) begin
      euidx_new[k] = alloc_ctr_new;
      if (batch_instr_valid_i[k]) begin
        alloc_ctr_new = alloc_ctr_new + CtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      instr_q     <= '0;
      euidx_q     <= '0;
      alloc_ctr_q <= '0;
    end else if (accept) begin
      pending_q <= batch_instr_valid_i;
      if (|batch_instr_valid_i) begin
        instr_q     <= batch_instr_i;
        euidx_q     <= euidx_new;
        alloc_ctr_q <= alloc_ctr_new;
        state_q     <= StDispatch;
      end else begin
        state_q <= StIdle;
      end
    end else begin
      // A full EU is deemed to have taken none of its lanes, so only blocked lanes stay pending.
      pending_q <= blocked;
      state_q   <= (|blocked) ? StRetry : StIdle;
    end
  end

  assign dispatched_instr_o             = instr_q;
  assign dispatched_instr_valid_o       = pending_q;
  assign dispatched_instr_alloc_euidx_o = euidx_q;

`ifdef FE_DISPATCH_STALL_CTR_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == StRetry && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_fe_instr_dispatcher.sv
// Scoreboard bench for fe_instr_dispatcher: directed spec scenarios followed by random traffic,
// checked against a lane-level reference model.
module tb_fe_instr_dispatcher;

  localparam int N     = 4;
  localparam int L     = 2;
  localparam int NEU   = 4;
  localparam int W     = 32;
  localparam int TOTAL = 400;
  localparam int DRAIN = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0][W-1:0] batch_instr;
  logic [N-1:0]        batch_instr_valid;
  logic                batch_valid;
  logic                batch_ready;
  logic [N-1:0][W-1:0] d_instr;
  logic [N-1:0]        d_valid;
  logic [N-1:0][L-1:0] d_euidx;
  logic [NEU-1:0]      eu_full;
`ifdef FE_DISPATCH_STALL_CTR_EN
  logic [15:0]         stall_cycles;
`endif

  always #5 clk = ~clk;

  fe_instr_dispatcher #(
    .NUM_PARALLEL_INSTR_DISPATCHES(N),
    .LOG2_NUM_EXEC_UNITS          (L),
    .INSTR_W                      (W)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .batch_instr_i                 (batch_instr),
    .batch_instr_valid_i           (batch_instr_valid),
    .batch_valid_i                 (batch_valid),
    .batch_ready_o                 (batch_ready),
    .dispatched_instr_o            (d_instr),
    .dispatched_instr_valid_o      (d_valid),
    .dispatched_instr_alloc_euidx_o(d_euidx),
    .eu_is_full_i                  (eu_full)
`ifdef FE_DISPATCH_STALL_CTR_EN
    ,
    .stall_cycles_o                (stall_cycles)
`endif
  );

  typedef struct {
    int          stamp;
    int          lane;
    logic [W-1:0] payload;
    int          euidx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: per-lane pending flag, fixed EU target and payload, plus a plain integer counter.
  bit           m_pend[N];
  int           m_eu[N];
  logic [W-1:0] m_pay[N];
  int           m_ctr;
  bit           m_retry;
  int           m_stall;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_eu[k]   = 0;
      m_pay[k]  = '0;
    end
    m_ctr   = 0;
    m_retry = 1'b0;
    m_stall = 0;
  endtask

  task automatic drive(input int s);
    reset             = 1'b0;
    batch_valid       = 1'b0;
    batch_instr_valid = '0;
    eu_full           = '0;
    for (int k = 0; k < N; k++) batch_instr[k] = $urandom;
    case (s)
      0, 6, 12, 13, 14, 15, 16, 19: begin batch_valid = 1'b1; batch_instr_valid = 4'b1111; end
      3:          begin batch_valid = 1'b1; batch_instr_valid = 4'b0111; end
      4:          begin batch_valid = 1'b1; batch_instr_valid = 4'b1010; end
      7, 8, 9:    begin batch_valid = 1'b1; batch_instr_valid = 4'b0001; eu_full = 4'b0100; end
      10, 21:     begin batch_valid = 1'b1; batch_instr_valid = 4'b0001; end
      17:         eu_full = 4'b1111;
      18:         begin reset = 1'b1; eu_full = 4'b1111; end
      20:         batch_valid = 1'b1;
      default: begin
        if (s >= 24 && s < TOTAL - DRAIN) begin
          batch_valid       = ($urandom_range(0, 3) != 0);
          batch_instr_valid = 4'($urandom);
          for (int e = 0; e < NEU; e++) eu_full[e] = ($urandom_range(0, 3) == 0);
          reset = ($urandom_range(0, 63) == 0);
        end
      end
    endcase
  endtask

  task automatic model_step(input int s);
    bit blocked_any;
    bit acc;
    bit any_pend;
    int rank;
    exp_t e;
`ifdef FE_DISPATCH_STALL_CTR_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
    if (reset) begin
      model_reset();
      return;
    end
    blocked_any = 1'b0;
    for (int k = 0; k < N; k++) if (m_pend[k] && eu_full[m_eu[k]]) blocked_any = 1'b1;
    check("batch_ready", batch_ready, !blocked_any);
    if (m_retry && m_stall < 65535) m_stall++;
    for (int k = 0; k < N; k++) if (m_pend[k] && !eu_full[m_eu[k]]) m_pend[k] = 1'b0;
    acc = batch_valid && !blocked_any;
    if (acc) begin
      rank = 0;
      for (int k = 0; k < N; k++) begin
        m_pend[k] = batch_instr_valid[k];
        if (batch_instr_valid[k]) begin
          m_eu[k]  = (m_ctr + rank) % NEU;
          m_pay[k] = batch_instr[k];
          rank++;
        end
      end
      m_ctr = (m_ctr + rank) % NEU;
    end
    any_pend = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (m_pend[k]) begin
        any_pend  = 1'b1;
        e.stamp   = s;
        e.lane    = k;
        e.payload = m_pay[k];
        e.euidx   = m_eu[k];
        exp_q.push_back(e);
      end
    end
    m_retry = !acc && any_pend;
  endtask

  initial begin
    model_reset();
    reset             = 1'b1;
    batch_valid       = 1'b0;
    batch_instr_valid = '0;
    batch_instr       = '0;
    eu_full           = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset ready", batch_ready, 1);
    check("reset valids", d_valid, 0);
    check("reset euidx", d_euidx, 0);
    check("reset payload", d_instr[0], 0);
`ifdef FE_DISPATCH_STALL_CTR_EN
    check("reset stall", stall_cycles, 0);
`endif
    fork
      begin : driver
        for (int s = 0; s < TOTAL; s++) begin
          @(negedge clk);
          drive(s);
        end
      end
      begin : model
        for (int s = 0; s < TOTAL; s++) begin
          @(negedge clk);
          #2;
          model_step(s);
        end
      end
      begin : monitor
        exp_t e;
        int   miss;
        @(negedge clk);
        for (int c = 0; c < TOTAL; c++) begin
          @(posedge clk);
          #1;
          for (int k = 0; k < N; k++) begin
            if (d_valid[k]) begin
              if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected valid: lane %0d valid at cycle %0d, none expected", k, c);
              end else begin
                e = exp_q.pop_front();
                check("dispatch cycle", c, e.stamp);
                check("dispatch lane", k, e.lane);
                check("dispatch payload", d_instr[k], e.payload);
                check("dispatch euidx", d_euidx[k], e.euidx);
              end
            end
          end
          miss = 0;
          while (exp_q.size() > 0 && exp_q[0].stamp <= c) begin
            e = exp_q.pop_front();
            miss++;
          end
          check("missing lane valids", miss, 0);
        end
      end
    join
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
